// File: rtl/png_record_buffer.sv
`timescale 1ns/1ps
// PNG record buffer: queues flagged {ip, port, payload} records in a small FIFO and serialises
// each one MSB-first onto a valid/ready word stream, counting records lost to overflow.
module png_record_buffer #(
  parameter int unsigned PAYLOAD_WIDTH = 336,
  parameter int unsigned OUT_WIDTH     = 64,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [PAYLOAD_WIDTH-1:0]   in_payload,
  input  logic [31:0]                in_ip,
  input  logic [15:0]                in_port,
  output logic [OUT_WIDTH-1:0]       m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [15:0]                drop_count
);

  localparam int unsigned RecW  = PAYLOAD_WIDTH + 48;
  localparam int unsigned Words = RecW / OUT_WIDTH;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  logic [RecW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic [0:0]      state_q;
  logic [RecW-1:0] sh_q;
  logic [IdxW-1:0] idx_q;
  logic            valid_q;
  logic            ovf_q;
  logic [15:0]     drop_q;

  logic hs, last_w, push, pop;

  always_comb begin
    empty  = (cnt_q == '0);
    full   = (cnt_q == CntW'(DEPTH));
    hs     = valid_q && m_ready;
    last_w = (idx_q == IdxW'(Words - 1));
    // The next record is fetched either from idle or on the final handshake, so no bubble.
    pop    = !empty && ((state_q == StIdle) || (hs && last_w));
    push   = in_valid && !full;
  end

  assign m_data     = sh_q[RecW-1 -: OUT_WIDTH];
  assign m_valid    = valid_q;
  assign m_last     = valid_q && last_w;
  assign count      = cnt_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_ip, in_port, in_payload};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= StIdle;
      sh_q     <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
      else if (!push && pop) cnt_q <= cnt_q - CntW'(1);

      ovf_q <= in_valid && full;
      if (in_valid && full && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;

      if (pop) begin
        sh_q    <= mem_q[rd_ptr_q];
        idx_q   <= '0;
        valid_q <= 1'b1;
        state_q <= StSend;
      end else if ((state_q == StSend) && hs) begin
        sh_q <= sh_q << OUT_WIDTH;
        if (last_w) begin
          idx_q   <= '0;
          valid_q <= 1'b0;
          state_q <= StIdle;
        end else begin
          idx_q <= idx_q + IdxW'(1);
        end
      end
    end
  end

endmodule
